// File: rtl/des_key_schedule.sv
// DES key-schedule engine: PC-1 on a 64-bit key, then 16 rotated C/D values
// presented one per round over a valid/ready handshake, encrypt or decrypt order.
module des_key_schedule #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [3:0]  round_idx,
  output logic [55:0] cd_key,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic {StIdle, StRound} state_e;

  // PC-1 source bit for each output position, stored zero-based.
  localparam logic [5:0] Pc1Tbl [56] = '{
    6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,  6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
    6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
    6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
    6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28, 6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3
  };

  // Position 1 sits at bit 0, so a DES left rotate moves bits toward bit 0.
  function automatic logic [27:0] rot_l(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  function automatic logic [27:0] rot_r(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  round_q, round_d;
  logic [55:0] cd_q, cd_d;
  logic        dec_q, dec_d;
  logic        par_q, par_d;
  logic        done_q, done_d;

  logic [55:0] pc1;
  logic        par_bad;
  logic        accept, hs, last, two_shift;

  always_comb begin
    pc1 = '0;
    for (int k = 0; k < 56; k++) begin
      pc1[k] = key_in[Pc1Tbl[k]];
    end
  end

  always_comb begin
    par_bad = 1'b0;
    for (int j = 0; j < 8; j++) begin
      par_bad = par_bad | ~(^key_in[8*j +: 8]);
    end
  end

  assign accept    = (state_q == StIdle) && start;
  assign hs        = (state_q == StRound) && rk_ready;
  assign last      = hs && (round_q == 4'd15);
  // Single-bit steps occur when leaving indices 0, 7 and 14 in both orders.
  assign two_shift = !((round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      round_q <= '0;
      cd_q    <= '0;
      dec_q   <= 1'b0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cd_q    <= cd_d;
      dec_q   <= dec_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRound;
      StRound: if (last)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    round_d = round_q;
    cd_d    = cd_q;
    dec_d   = dec_q;
    par_d   = par_q;
    done_d  = last;
    if (accept) begin
      round_d = '0;
      dec_d   = decrypt;
      par_d   = CHECK_PARITY ? par_bad : 1'b0;
      cd_d    = decrypt ? pc1 : {rot_l(pc1[55:28], 1'b0), rot_l(pc1[27:0], 1'b0)};
    end else if (hs) begin
      if (last) begin
        round_d = '0;
      end else begin
        round_d = round_q + 4'd1;
        cd_d    = dec_q ? {rot_r(cd_q[55:28], two_shift), rot_r(cd_q[27:0], two_shift)}
                        : {rot_l(cd_q[55:28], two_shift), rot_l(cd_q[27:0], two_shift)};
      end
    end
  end

  // Outputs
  always_comb begin
    busy       = (state_q == StRound);
    rk_valid   = (state_q == StRound);
    round_idx  = round_q;
    cd_key     = cd_q;
    done       = done_q;
    parity_err = par_q;
  end

endmodule
